// File: rtl/pc_sequencer.sv
// pc_sequencer: owns the architectural fetch PC and sequences instruction fetch.
// Each cycle the next PC is chosen from PC+2, a resolved branch target, hold
// (stall or instruction-memory wait) or halt. The block drives the fetch
// address, fetch-valid, the one-cycle IF/ID squash and the halted flag.
//
// Optional feature: define PC_SEQ_BRCNT_EN to add a 16-bit saturating count
// of accepted redirects on output br_count. The default build leaves it out.
module pc_sequencer #(
  parameter int              PC_W     = 16,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            imem_rdy,
  input  logic            stall,
  input  logic            br_taken,
  input  logic [PC_W-1:0] br_target,
  input  logic            hlt_dec,
  output logic [PC_W-1:0] pc,
  output logic [PC_W-1:0] pc_plus2,
  output logic            fetch_valid,
  output logic            flush,
  output logic            halted
`ifdef PC_SEQ_BRCNT_EN
  ,
  output logic [15:0]     br_count
`endif
);

  // Sequencer states. The encoding is kept as plain constants so the state
  // register can be probed and compared against older netlists.
  localparam logic [1:0] S_IDLE     = 2'd0;
  localparam logic [1:0] S_RUN      = 2'd1;
  localparam logic [1:0] S_WAIT_MEM = 2'd2;
  localparam logic [1:0] S_HALT     = 2'd3;

  logic [1:0]      state;
  logic [1:0]      state_next;
  logic [PC_W-1:0] pc_next;
  logic [PC_W-1:0] br_target_even;
  logic            br_accept;

  // Sequential successor wraps naturally modulo 2^PC_W.
  assign pc_plus2 = pc + PC_W'(2);

  // Instructions are halfword aligned, so the target LSB is dropped on load.
  assign br_target_even = {br_target[PC_W-1:1], 1'b0};

  // Fetch is live whenever the sequencer is running or waiting on memory.
  assign fetch_valid = (state == S_RUN) || (state == S_WAIT_MEM);
  assign halted      = (state == S_HALT);

  // Next-state and next-PC selection. A taken branch wins in every active
  // state; IDLE ignores all inputs for its single cycle.
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    state_next = state;
    pc_next    = pc;
    br_accept  = 1'b0;
    case (state)
      S_IDLE: begin
        state_next = S_RUN;
      end
      S_RUN: begin
        if (br_taken) begin
          br_accept = 1'b1;
          pc_next   = br_target_even;
        end else if (hlt_dec) begin
          state_next = S_HALT;
        end else if (stall) begin
          state_next = S_RUN;
        end else if (!imem_rdy) begin
          state_next = S_WAIT_MEM;
        end else begin
          pc_next = pc_plus2;
        end
      end
      S_WAIT_MEM: begin
        if (br_taken) begin
          // Redirect abandons the outstanding fetch.
          br_accept  = 1'b1;
          pc_next    = br_target_even;
          state_next = S_RUN;
        end else if (imem_rdy) begin
          state_next = S_RUN;
          if (!stall) begin
            pc_next = pc_plus2;
          end
        end
      end
      S_HALT: begin
        // An older branch resolving past a wrong-path HLT restarts fetch.
        if (br_taken) begin
          br_accept  = 1'b1;
          pc_next    = br_target_even;
          state_next = S_RUN;
        end
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  // State, PC and squash registers; reset discards any pending redirect.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: registers use non-blocking assignments so every flop samples
    // values from before the edge regardless of statement order.
    if (rst) begin
      state <= S_IDLE;
      pc    <= RESET_PC;
      flush <= 1'b0;
    end else begin
      state <= state_next;
      pc    <= pc_next;
      flush <= br_accept;
    end
  end

`ifdef PC_SEQ_BRCNT_EN
  // Saturating count of accepted redirects.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      br_count <= 16'h0000;
    end else if (br_accept && (br_count != 16'hFFFF)) begin
      br_count <= br_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// Testbench for pc_sequencer: directed scenarios followed by random traffic.
// A driver applies inputs on the falling edge and pushes the expected
// post-edge outputs from a behavioural model; a monitor pops and compares
// just after each rising edge.
module tb_pc_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        imem_rdy = 1'b0;
  logic        stall = 1'b0;
  logic        br_taken = 1'b0;
  logic [15:0] br_target = 16'h0000;
  logic        hlt_dec = 1'b0;
  logic [15:0] pc;
  logic [15:0] pc_plus2;
  logic        fetch_valid;
  logic        flush;
  logic        halted;
`ifdef PC_SEQ_BRCNT_EN
  logic [15:0] br_count;
`endif

  pc_sequencer #(.PC_W(16), .RESET_PC(16'h0000)) dut (
    .clk         (clk),
    .rst         (rst),
    .imem_rdy    (imem_rdy),
    .stall       (stall),
    .br_taken    (br_taken),
    .br_target   (br_target),
    .hlt_dec     (hlt_dec),
    .pc          (pc),
    .pc_plus2    (pc_plus2),
    .fetch_valid (fetch_valid),
    .flush       (flush),
    .halted      (halted)
`ifdef PC_SEQ_BRCNT_EN
    ,
    .br_count    (br_count)
`endif
  );

  always #5 clk = ~clk;

  typedef enum {M_IDLE, M_RUN, M_WAIT, M_HALT} mode_t;

  typedef struct {
    logic [15:0] pc;
    logic [15:0] pc_plus2;
    logic        fv;
    logic        flush;
    logic        halted;
    logic [15:0] cnt;
  } exp_t;

  exp_t sb[$];

  int n_cmp = 0;
  int n_mis = 0;

  // Reference model state, kept as plain integers.
  mode_t m_mode = M_IDLE;
  int    m_pc   = 0;
  bit    m_flush = 1'b0;
  int    m_cnt  = 0;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // Apply one cycle of inputs and record what the outputs must be after it.
  task automatic step(input bit r, input bit rdy, input bit stl, input bit br,
                      input logic [15:0] tgt, input bit hlt);
    exp_t e;
    bit   accepted;
    @(negedge clk);
    rst       = r;
    imem_rdy  = rdy;
    stall     = stl;
    br_taken  = br;
    br_target = tgt;
    hlt_dec   = hlt;
    if (r) begin
      m_mode  = M_IDLE;
      m_pc    = 0;
      m_flush = 1'b0;
      m_cnt   = 0;
    end else begin
      accepted = br && (m_mode != M_IDLE);
      m_flush  = accepted;
      if (accepted) begin
        m_pc   = int'(tgt) & 32'hFFFE;
        m_mode = M_RUN;
        if (m_cnt < 65535) m_cnt++;
      end else begin
        case (m_mode)
          M_IDLE: m_mode = M_RUN;
          M_RUN: begin
            if (hlt)       m_mode = M_HALT;
            else if (stl)  m_mode = M_RUN;
            else if (!rdy) m_mode = M_WAIT;
            else           m_pc = (m_pc + 2) % 65536;
          end
          M_WAIT: begin
            if (rdy) begin
              m_mode = M_RUN;
              if (!stl) m_pc = (m_pc + 2) % 65536;
            end
          end
          default: ;
        endcase
      end
    end
    e.pc       = 16'(m_pc);
    e.pc_plus2 = 16'((m_pc + 2) % 65536);
    e.fv       = (m_mode == M_RUN) || (m_mode == M_WAIT);
    e.flush    = m_flush;
    e.halted   = (m_mode == M_HALT);
    e.cnt      = 16'(m_cnt);
    sb.push_back(e);
  endtask

  task automatic go(input bit rdy, input bit stl, input bit br,
                    input logic [15:0] tgt, input bit hlt);
    step(1'b0, rdy, stl, br, tgt, hlt);
  endtask

  // Monitor: compare DUT outputs against the oldest expectation.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check("pc", pc, e.pc);
        check("pc_plus2", pc_plus2, e.pc_plus2);
        check("fetch_valid", 16'(fetch_valid), 16'(e.fv));
        check("flush", 16'(flush), 16'(e.flush));
        check("halted", 16'(halted), 16'(e.halted));
`ifdef PC_SEQ_BRCNT_EN
        check("br_count", br_count, e.cnt);
`endif
      end
    end
  end

  // Driver: directed scenarios, then random traffic.
  initial begin
    int budget;
    rst = 1'b1;

    // Reset, release, free-running fetch.
    step(1'b1, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b0);
    for (int i = 0; i < 5; i++) go(1'b1, 1'b0, 1'b0, 16'h0000, 1'b0);

    // Stall at 0010 for three cycles.
    go(1'b1, 1'b0, 1'b1, 16'h0010, 1'b0);
    for (int i = 0; i < 3; i++) go(1'b1, 1'b1, 1'b0, 16'h0000, 1'b0);
    for (int i = 0; i < 2; i++) go(1'b1, 1'b0, 1'b0, 16'h0000, 1'b0);

    // Redirect with stall at 0020, odd target, then back-to-back redirects.
    go(1'b1, 1'b0, 1'b1, 16'h0020, 1'b0);
    go(1'b1, 1'b1, 1'b1, 16'h0101, 1'b0);
    go(1'b1, 1'b0, 1'b0, 16'h0000, 1'b0);
    go(1'b1, 1'b0, 1'b1, 16'h0300, 1'b0);
    go(0, 1'b1, 1'b1, 16'h0401, 1'b1);
    go(1'b1, 1'b0, 1'b0, 16'h0000, 1'b0);

    // Memory wait at 0030, then redirect in the middle of a wait.
    go(1'b1, 1'b0, 1'b1, 16'h0030, 1'b0);
    for (int i = 0; i < 4; i++) go(1'b0, 1'b0, 1'b0, 16'h0000, 1'b0);
    go(1'b1, 1'b0, 1'b0, 16'h0000, 1'b0);
    for (int i = 0; i < 2; i++) go(1'b0, 1'b0, 1'b0, 16'h0000, 1'b0);
    go(1'b0, 1'b1, 1'b1, 16'h0200, 1'b0);
    go(1'b0, 1'b0, 1'b0, 16'h0000, 1'b0);
    go(1'b1, 1'b1, 1'b0, 16'h0000, 1'b0);

    // Halt at 0040 with noisy inputs, restart by branch, reset mid-halt.
    go(1'b1, 1'b0, 1'b1, 16'h0040, 1'b0);
    go(1'b1, 1'b0, 1'b0, 16'h0000, 1'b1);
    for (int i = 0; i < 20; i++)
      go(1'($urandom_range(1)), 1'($urandom_range(1)), 1'b0, 16'h0000, 1'($urandom_range(1)));
    go(1'b1, 1'b1, 1'b1, 16'h0080, 1'b1);
    go(1'b1, 1'b0, 1'b0, 16'h0000, 1'b1);
    for (int i = 0; i < 3; i++) go(1'b1, 1'b0, 1'b0, 16'h0000, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b0);
    go(1'b1, 1'b0, 1'b1, 16'h0500, 1'b0);
    go(1'b1, 1'b0, 1'b0, 16'h0000, 1'b0);

    // Wrap at the top of the address space, including an odd target.
    go(1'b1, 1'b0, 1'b1, 16'hFFFE, 1'b0);
    go(1'b1, 1'b0, 1'b0, 16'h0000, 1'b0);
    go(1'b1, 1'b0, 1'b1, 16'hFFFF, 1'b0);
    go(1'b1, 1'b0, 1'b0, 16'h0000, 1'b0);
    go(1'b1, 1'b0, 1'b0, 16'h0000, 1'b0);

    // Random traffic with occasional resets.
    for (int i = 0; i < 3000; i++) begin
      step(1'($urandom_range(99) == 0),
           1'($urandom_range(3) != 0),
           1'($urandom_range(4) == 0),
           1'($urandom_range(6) == 0),
           16'($urandom),
           1'($urandom_range(14) == 0));
    end

    // Let the monitor drain the scoreboard, with a bounded wait.
    budget = 0;
    while ((sb.size() > 0) && (budget < 10)) begin
      @(negedge clk);
      budget++;
    end
    if (sb.size() > 0) begin
      n_mis++;
      $display("FAIL drain: got %0d expectations left, expected 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
